// File: rtl/pipeline_controller.sv
// Control sequencer for the fetch/decode/action pipeline: redirects, stalls, halt and interrupt entry.
// Optional build macro PIPE_PERF_CNT_EN adds saturating cycle/stall/flush counters.
module pipeline_controller #(
  parameter int                PC_SIZE  = 16,
  parameter logic [PC_SIZE-1:0] INT_BASE = 16'h0010
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               d_valid,
  input  logic [PC_SIZE-1:0] d_pc,
  input  logic               d_halt,
  input  logic               d_interrupt,
  input  logic [3:0]         d_int_code,
  input  logic               d_branch,
  input  logic               predict_taken,
  input  logic               feedback_taken,
  input  logic [PC_SIZE-1:0] predict_target,
  input  logic [PC_SIZE-1:0] feedback_target,
  input  logic               a_mem_access,
  input  logic               mem_ready,
  input  logic               int_ack,
  input  logic               resume,
  output logic               fetch_en,
  output logic               pc_load,
  output logic [PC_SIZE-1:0] pc_target,
  output logic               decode_stall,
  output logic               decode_flush,
  output logic               action_hold,
  output logic               halted,
  output logic [PC_SIZE-1:0] epc,
  output logic               epc_valid
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]        perf_cycles,
  output logic [15:0]        perf_stalls,
  output logic [15:0]        perf_flushes
`endif
);

  localparam logic [2:0] START    = 3'd0;
  localparam logic [2:0] RUN      = 3'd1;
  localparam logic [2:0] REDIRECT = 3'd2;
  localparam logic [2:0] MEM_WAIT = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] HALTED   = 3'd5;

  localparam logic [PC_SIZE-1:0] PC_ONE = {{(PC_SIZE-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [PC_SIZE-1:0] epc_q, epc_d;
  logic               epc_valid_q, epc_valid_d;
  logic [PC_SIZE-1:0] halt_pc_q, halt_pc_d;

  logic               mem_wait;
  logic               mispredict;
  logic [PC_SIZE-1:0] d_pc_inc;
  logic [PC_SIZE-1:0] halt_pc_inc;
  logic [PC_SIZE-1:0] int_target;

  assign mem_wait    = a_mem_access & ~mem_ready;
  assign mispredict  = d_branch & ((predict_taken != feedback_taken) |
                                   (feedback_taken & (predict_target != feedback_target)));
  assign d_pc_inc    = d_pc + PC_ONE;
  assign halt_pc_inc = halt_pc_q + PC_ONE;
  assign int_target  = {INT_BASE[PC_SIZE-1:4], d_int_code};

  assign epc       = epc_q;
  assign epc_valid = epc_valid_q;

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    epc_valid_d  = epc_valid_q & ~int_ack;
    halt_pc_d    = halt_pc_q;
    fetch_en     = 1'b0;
    pc_load      = 1'b0;
    pc_target    = '0;
    decode_stall = 1'b0;
    decode_flush = 1'b0;
    action_hold  = 1'b0;
    halted       = 1'b0;

    case (state_q)
      START: begin
        decode_flush = 1'b1;
        state_d      = RUN;
      end

      RUN: begin
        fetch_en = 1'b1;
        if (mem_wait) begin
          fetch_en     = 1'b0;
          decode_stall = 1'b1;
          action_hold  = 1'b1;
          state_d      = MEM_WAIT;
        end else if (d_valid && d_halt) begin
          fetch_en     = 1'b0;
          decode_flush = 1'b1;
          halt_pc_d    = d_pc;
          state_d      = DRAIN;
        end else if (d_valid && d_interrupt) begin
          // A second interrupt while one is in service is simply dropped.
          if (!epc_valid_q) begin
            epc_d       = d_pc_inc;
            epc_valid_d = 1'b1;
            pc_load     = 1'b1;
            pc_target   = int_target;
            state_d     = REDIRECT;
          end
        end else if (d_valid && mispredict) begin
          pc_load   = 1'b1;
          pc_target = feedback_taken ? feedback_target : d_pc_inc;
          state_d   = REDIRECT;
        end
      end

      REDIRECT: begin
        decode_flush = 1'b1;
        // The wrong-path flush still happens when a mem wait starts here, but fetch must not run ahead.
        if (mem_wait) begin
          decode_stall = 1'b1;
          action_hold  = 1'b1;
          state_d      = MEM_WAIT;
        end else begin
          fetch_en = 1'b1;
          state_d  = RUN;
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          fetch_en = 1'b1;
          state_d  = RUN;
        end else begin
          decode_stall = 1'b1;
          action_hold  = 1'b1;
        end
      end

      DRAIN: begin
        decode_flush = 1'b1;
        if (mem_wait) begin
          action_hold = 1'b1;
        end else begin
          state_d = HALTED;
        end
      end

      HALTED: begin
        halted       = 1'b1;
        decode_flush = 1'b1;
        if (resume) begin
          pc_load   = 1'b1;
          pc_target = halt_pc_inc;
          state_d   = REDIRECT;
        end
      end

      default: begin
        decode_flush = 1'b1;
        state_d      = START;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= START;
      epc_q       <= '0;
      epc_valid_q <= 1'b0;
      halt_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      epc_q       <= epc_d;
      epc_valid_q <= epc_valid_d;
      halt_pc_q   <= halt_pc_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] perf_cycles_q, perf_stalls_q, perf_flushes_q;
  logic        cnt_cycle, cnt_stall, cnt_flush;

  assign cnt_cycle = (state_q != HALTED);
  assign cnt_stall = (state_q == MEM_WAIT);
  assign cnt_flush = decode_flush && (state_q != START) && (state_q != HALTED);

  // Each counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_cycles_q  <= '0;
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (cnt_cycle && (perf_cycles_q != 16'hFFFF)) perf_cycles_q <= perf_cycles_q + 16'd1;
      if (cnt_stall && (perf_stalls_q != 16'hFFFF)) perf_stalls_q <= perf_stalls_q + 16'd1;
      if (cnt_flush && (perf_flushes_q != 16'hFFFF)) perf_flushes_q <= perf_flushes_q + 16'd1;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_stalls  = perf_stalls_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule
